// File: rtl/mem_sweep_checker.sv
// mem_sweep_checker
//   In-system RAM checker. It can fill every word of a block RAM with an
//   address-derived pattern, then reads every word back and compares it with
//   the same pattern. It reports pass/fail, the number of bad words
//   (saturating) and the first bad address.
//
//   Pattern: P(a) = low WID_MEM bits of {(seed_q ^ a)} replicated
//   ceil(WID_MEM/32) times. seed_q is the seed latched at start.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   start          request a sweep (sampled only while idle)
//   fill           sampled with start: 1 = fill then check, 0 = check only
//   seed           pattern seed, sampled with start
//   abort          synchronous abort of the current sweep
//   busy           high while a sweep is in progress
//   done           one-cycle pulse when a sweep completes (not on abort)
//   pass           err_count == 0, valid from the done pulse onwards
//   err_count      number of mismatching words, saturating
//   first_err_addr address of the first mismatch, 0 if none
//   mem_raddr      RAM read address (zero-extended)
//   mem_waddr      RAM write address (zero-extended)
//   mem_din        RAM write data
//   mem_we         RAM write enable
//   mem_dout       RAM read data, valid one cycle after mem_raddr
module mem_sweep_checker #(
  parameter int WID_MEM   = 256,
  parameter int DEPTH_MEM = 64,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               fill,
  input  logic [31:0]        seed,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_count,
  output logic [31:0]        first_err_addr,
  output logic [31:0]        mem_raddr,
  output logic [31:0]        mem_waddr,
  output logic [WID_MEM-1:0] mem_din,
  output logic               mem_we,
  input  logic [WID_MEM-1:0] mem_dout
);

  localparam int AW  = $clog2(DEPTH_MEM + 1);
  localparam int REP = (WID_MEM + 31) / 32;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [WID_MEM-1:0] pattern(input logic [31:0] s,
                                                 input logic [31:0] a);
    logic [REP*32-1:0] rep;
    rep = {REP{s ^ a}};
    return rep[WID_MEM-1:0];
  endfunction

  state_t           state;
  state_t           state_n;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cnt_n;
  logic [31:0]      seed_q;
  logic             issued;     // a read address was presented this cycle
  logic             cmp_valid;  // mem_dout holds the word for cmp_addr
  logic [31:0]      cmp_addr;
  logic             mismatch;
  logic [CNT_W-1:0] err_next;
  logic             abort_hit;
  logic             start_hit;

  assign abort_hit = abort && (state != ST_IDLE);
  // Abort has priority over start when both arrive while idle.
  assign start_hit = (state == ST_IDLE) && start && !abort;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every variable gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (start_hit) begin
          state_n = fill ? ST_FILL : ST_READ;
          cnt_n   = '0;
        end
      end
      ST_FILL: begin
        if (cnt == LAST_ADDR) begin
          state_n = ST_READ;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      ST_READ: begin
        // The counter stops on the last address; it never wraps.
        if (cnt == LAST_ADDR) state_n = ST_DRAIN;
        else                  cnt_n   = cnt + AW'(1);
      end
      ST_DRAIN: state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    if (abort_hit) state_n = ST_IDLE;
  end

  // ---------------------------------------------------------------------
  // Compare stage: mem_dout lines up with cmp_addr when cmp_valid is set.
  // ---------------------------------------------------------------------
  always_comb begin
    mismatch = cmp_valid && (mem_dout != pattern(seed_q, cmp_addr));
    err_next = err_count;
    if (mismatch && (err_count != {CNT_W{1'b1}}))
      err_next = err_count + CNT_W'(1);
  end

  // ---------------------------------------------------------------------
  // Registered outputs and the read/compare pipeline
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      mem_raddr      <= '0;
      mem_waddr      <= '0;
      mem_din        <= '0;
      mem_we         <= 1'b0;
      seed_q         <= '0;
      issued         <= 1'b0;
      cmp_valid      <= 1'b0;
      cmp_addr       <= '0;
    end else begin
      done      <= 1'b0;
      mem_we    <= 1'b0;
      issued    <= 1'b0;
      cmp_valid <= issued;
      cmp_addr  <= mem_raddr;

      if (abort_hit) begin
        // Partial err_count / first_err_addr are kept for inspection.
        busy      <= 1'b0;
        pass      <= 1'b0;
        cmp_valid <= 1'b0;
      end else begin
        err_count <= err_next;
        // err_count only leaves zero through a mismatch, so zero means
        // this is the first one.
        if (mismatch && (err_count == '0)) first_err_addr <= cmp_addr;

        case (state)
          ST_IDLE: begin
            if (start_hit) begin
              seed_q         <= seed;
              err_count      <= '0;
              first_err_addr <= '0;
              pass           <= 1'b0;
              busy           <= 1'b1;
            end
          end
          ST_FILL: begin
            mem_we    <= 1'b1;
            mem_waddr <= 32'(cnt);
            mem_din   <= pattern(seed_q, 32'(cnt));
          end
          ST_READ: begin
            mem_raddr <= 32'(cnt);
            issued    <= 1'b1;
          end
          ST_DONE: begin
            // The last word is compared on this same edge, so use err_next.
            done <= 1'b1;
            pass <= (err_next == '0);
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_sweep_checker.sv
// Testbench for mem_sweep_checker: a table of full sweeps against an ideal
// RAM model (with optional preload and bit-0 corruption at addresses 5 and
// 40), followed by hand-written abort, reset and saturation sequences.
module tb_mem_sweep_checker;

  localparam int W = 256;
  localparam int D = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             fill = 1'b0;
  logic [31:0]      seed = '0;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      err_count;
  logic [31:0]      first_err_addr;
  logic [31:0]      mem_raddr;
  logic [31:0]      mem_waddr;
  logic [W-1:0]     mem_din;
  logic             mem_we;
  logic [W-1:0]     mem_dout;

  // Second instance: narrow counter, 40-bit words, RAM reads back zeros.
  logic             start_s = 1'b0;
  logic             fill_s = 1'b0;
  logic [31:0]      seed_s = 32'hFFFF_FFFF;
  logic             abort_s = 1'b0;
  logic             busy_s;
  logic             done_s;
  logic             pass_s;
  logic [3:0]       err_s;
  logic [31:0]      first_s;
  logic [31:0]      raddr_s;
  logic [31:0]      waddr_s;
  logic [39:0]      din_s;
  logic             we_s;
  logic [39:0]      dout_s = '0;

  logic             preload = 1'b0;
  logic             corrupt = 1'b0;
  logic [W-1:0]     ram [D];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_sweep_checker #(.WID_MEM(W), .DEPTH_MEM(D), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .fill(fill), .seed(seed),
    .abort(abort), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout)
  );

  mem_sweep_checker #(.WID_MEM(40), .DEPTH_MEM(D), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .start(start_s), .fill(fill_s), .seed(seed_s),
    .abort(abort_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .first_err_addr(first_s),
    .mem_raddr(raddr_s), .mem_waddr(waddr_s), .mem_din(din_s),
    .mem_we(we_s), .mem_dout(dout_s)
  );

  // Ideal RAM with one cycle of read latency. Preload writes word a = a
  // replicated; corrupt flips bit 0 of the words read at 5 and 40.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < D; i++) ram[i] <= {8{32'(i)}};
    end else if (mem_we) begin
      ram[mem_waddr[5:0]] <= mem_din;
    end
    mem_dout <= ram[mem_raddr[5:0]] ^
                ((corrupt && (mem_raddr == 32'd5 || mem_raddr == 32'd40)) ?
                 {{(W-1){1'b0}}, 1'b1} : {W{1'b0}});
  end

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_preload();
    @(posedge clk); #1 preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
  endtask

  // Start in cycle 0 and watch cycles 1..400 (sampled 1 time unit after
  // each edge). A second start pulse is driven in cycle restart_at if > 1.
  task automatic run_sweep(input logic f, input logic [31:0] s,
                           input int restart_at, output int done_cyc,
                           output int we_cnt, output logic [W-1:0] din3);
    done_cyc = -1;
    we_cnt   = 0;
    din3     = '0;
    @(posedge clk); #1;
    start = 1'b1; fill = f; seed = s;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (restart_at > 1 && k == restart_at) start = 1'b1;
      if (restart_at > 1 && k == restart_at + 1) start = 1'b0;
      if (mem_we) begin
        we_cnt++;
        if (mem_waddr == 32'd3) din3 = mem_din;
      end
      if (done) begin
        done_cyc = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        f;
    logic [31:0] s;
    logic        pre;
    logic        cor;
    int          restart_at;
    int          exp_done;
    int          exp_we;
    logic        exp_pass;
    logic [15:0] exp_err;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          done_cyc;
    int          we_cnt;
    int          seen;
    logic [W-1:0] din3;

    //          fill  seed          pre   cor   rst  done we  pass  err     first
    vecs[0] = '{1'b1, 32'hA5A50000, 1'b0, 1'b0, 0,  131, 64, 1'b1, 16'd0,  32'd0};
    vecs[1] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 0,  67,  0,  1'b1, 16'd0,  32'd0};
    vecs[2] = '{1'b1, 32'h12345678, 1'b0, 1'b1, 0,  131, 64, 1'b0, 16'd2,  32'd5};
    vecs[3] = '{1'b1, 32'hA5A50000, 1'b0, 1'b0, 10, 131, 64, 1'b1, 16'd0,  32'd0};
    vecs[4] = '{1'b0, 32'h0000FFFF, 1'b1, 1'b0, 0,  67,  0,  1'b0, 16'd64, 32'd0};
    vecs[5] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 0,  67,  0,  1'b0, 16'd2,  32'd5};

    // Reset state
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_count", err_count, 16'd0);
    check("rst_first_err", first_err_addr, 32'd0);
    check("rst_raddr", mem_raddr, 32'd0);
    check("rst_waddr", mem_waddr, 32'd0);
    check("rst_din", mem_din, '0);
    check("rst_we", mem_we, 1'b0);

    // Asynchronous reset in the middle of a check-only sweep that is
    // accumulating errors.
    do_preload();
    @(posedge clk); #1;
    start = 1'b1; fill = 1'b0; seed = 32'h0000FFFF;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    check("midread_busy", busy, 1'b1);
    check("midread_raddr", mem_raddr, 32'd28);
    check("midread_err_nonzero", err_count != 16'd0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_err_count", err_count, 16'd0);
    check("async_rst_raddr", mem_raddr, 32'd0);
    check("async_rst_we_done_pass", {mem_we, done, pass}, 3'b000);
    #2 reset = 1'b0;

    // Table of full sweeps; the first one also shows a normal sweep after
    // the mid-sweep reset.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre) do_preload();
      corrupt = vecs[i].cor;
      run_sweep(vecs[i].f, vecs[i].s, vecs[i].restart_at, done_cyc, we_cnt, din3);
      check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
      check($sformatf("v%0d_we_cycles", i), we_cnt, vecs[i].exp_we);
      check($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
      check($sformatf("v%0d_err_count", i), err_count, vecs[i].exp_err);
      check($sformatf("v%0d_first_err", i), first_err_addr, vecs[i].exp_first);
      check($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
      if (vecs[i].f)
        check($sformatf("v%0d_din_addr3", i), din3, {8{vecs[i].s ^ 32'd3}});
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d_done_single", i), done, 1'b0);
      check($sformatf("v%0d_pass_hold", i), pass, vecs[i].exp_pass);
      check($sformatf("v%0d_err_hold", i), err_count, vecs[i].exp_err);
      corrupt = 1'b0;
    end

    // Abort during FILL
    @(posedge clk); #1;
    start = 1'b1; fill = 1'b1; seed = 32'hA5A50000;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
    end
    check("pre_abort_we", mem_we, 1'b1);
    check("pre_abort_busy", busy, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_we", mem_we, 1'b0);
    check("abort_pass", pass, 1'b0);
    seen = 0;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk); #1;
      if (done || mem_we) seen = 1;
    end
    check("abort_no_done_or_write", seen, 0);

    // Abort and start together while idle: start is ignored.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_start_idle_still", busy, 1'b0);

    // Saturation on the CNT_W=4 instance: every word mismatches.
    @(posedge clk); #1;
    start_s = 1'b1;
    done_cyc = -1;
    we_cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 1) start_s = 1'b0;
      if (k == 12) check("sat_raddr_c12", raddr_s, 32'd10);
      if (we_s) we_cnt++;
      if (done_s) begin
        done_cyc = k;
        break;
      end
    end
    check("sat_done_cycle", done_cyc, 67);
    check("sat_err_count", err_s, 4'd15);
    check("sat_first_err", first_s, 32'd0);
    check("sat_pass", pass_s, 1'b0);
    check("sat_busy", busy_s, 1'b0);
    check("sat_no_writes", we_cnt, 0);
    check("sat_waddr_din", {waddr_s, din_s}, 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
